bound_arb: RTL and testbench

BOUND_ARB -- requirements
Module: bound_arb

---
 rtl/bound_arb_pkg.sv | 16 +
 rtl/bound_clamp.sv | 36 +++
 rtl/bound_arb.sv | 167 ++++++++++++++++
 tb/tb_bound_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bound_arb_pkg.sv
// Shared constants for the bound_arb clamp block.
//   RST_MIN / RST_MAX : clamp range loaded at reset
//   FIFO_DEPTH        : output FIFO entries (also the occupancy ceiling)
//   SAT_W             : width of the saturated-vector counter
package bound_arb_pkg;
    localparam int RST_MIN    = -32;
    localparam int RST_MAX    = 31;
    localparam int FIFO_DEPTH = 3;
    localparam int FIFO_PW    = 2;
    localparam int SAT_W      = 16;

    // Advance a FIFO pointer, wrapping at FIFO_DEPTH (not a power of two).
    function automatic logic [FIFO_PW-1:0] fifo_inc(input logic [FIFO_PW-1:0] p);
        return (p == FIFO_PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
endpackage

// File: rtl/bound_clamp.sv
// Combinational COLS-lane clamp.
//   x       : COLS signed AB_BW lanes, lane c at [(c+1)*AB_BW-1 -: AB_BW]
//   lo, hi  : signed BO_BW bounds (lo <= hi guaranteed by the caller)
//   y       : COLS signed BO_BW lanes, same packing
//   clamped : at least one lane was pulled to a bound
module bound_clamp
    import bound_arb_pkg::*;
#(
    parameter int COLS  = 5,
    parameter int AB_BW = 25,
    parameter int BO_BW = 8
) (
    input  logic [COLS*AB_BW-1:0] x,
    input  logic [BO_BW-1:0]      lo,
    input  logic [BO_BW-1:0]      hi,
    output logic [COLS*BO_BW-1:0] y,
    output logic                  clamped
);
    logic [COLS-1:0] lane_clp;

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        logic signed [AB_BW-1:0] xv, lo_x, hi_x;
        logic below, above;

        assign xv   = x[(c+1)*AB_BW-1 -: AB_BW];
        // Bounds are sign-extended so the compare happens at full lane width.
        assign lo_x = {{(AB_BW-BO_BW){lo[BO_BW-1]}}, lo};
        assign hi_x = {{(AB_BW-BO_BW){hi[BO_BW-1]}}, hi};
        assign below = xv < lo_x;
        assign above = xv > hi_x;
        assign y[(c+1)*BO_BW-1 -: BO_BW] = below ? lo : (above ? hi : xv[BO_BW-1:0]);
        assign lane_clp[c] = below | above;
    end

    assign clamped = |lane_clp;
endmodule

// File: rtl/bound_arb.sv
// Round-robin arbiter in front of a shared clamp datapath.
//   i_req_valid/i_req_data/o_req_ready : NREQ requester streams, one-hot grant
//   i_cfg_we/i_cfg_min/i_cfg_max       : clamp range write (deferred until idle)
//   o_cfg_err                          : pulse on min>max write
//   o_valid/o_data/o_src/i_ready       : clamped result stream (3-entry FIFO)
//   o_busy                             : vectors in flight or config pending
//   o_sat_cnt                          : vectors with any clamped lane since last config
module bound_arb
    import bound_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int COLS  = 5,
    parameter int AB_BW = 25,
    parameter int BO_BW = 8,
    localparam int SRC_W = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             i_req_valid,
    input  logic [NREQ*COLS*AB_BW-1:0]  i_req_data,
    output logic [NREQ-1:0]             o_req_ready,
    input  logic                        i_cfg_we,
    input  logic [BO_BW-1:0]            i_cfg_min,
    input  logic [BO_BW-1:0]            i_cfg_max,
    output logic                        o_cfg_err,
    output logic                        o_valid,
    output logic [COLS*BO_BW-1:0]       o_data,
    output logic [SRC_W-1:0]            o_src,
    input  logic                        i_ready,
    output logic                        o_busy,
    output logic [SAT_W-1:0]            o_sat_cnt
);
    localparam int VW    = COLS * AB_BW;
    localparam int OW    = COLS * BO_BW;
    localparam int EW    = SRC_W + OW;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CW + 1;

    logic [SRC_W-1:0]                ptr, gidx;
    logic [NREQ-1:0]                 grant;
    logic                            xfer, allow;
    logic [VW-1:0]                   sel_data;
    logic [OW-1:0]                   clp_data;
    logic                            clp_any;
    logic                            stage_vld;
    logic [OW-1:0]                   stage_data;
    logic [SRC_W-1:0]                stage_src;
    logic [FIFO_DEPTH-1:0][EW-1:0]   mem;
    logic [FIFO_PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]                   cnt;
    logic [OCC_W-1:0]                occ;
    logic                            push, pop;
    logic [BO_BW-1:0]                cur_min, cur_max, pend_min, pend_max;
    logic                            pend, cfg_ok, apply, cfg_err;
    logic [SAT_W-1:0]                sat_cnt;

    assign occ   = {1'b0, cnt} + {{CW{1'b0}}, stage_vld};
    // Capping occupancy at FIFO_DEPTH guarantees the stage always has a free
    // FIFO slot, so the stage never stalls and needs no ready of its own.
    assign allow = !rst && !pend && (occ < OCC_W'(FIFO_DEPTH));

    // Round-robin: first valid requester after the last granted one.
    always_comb begin
        logic             found;
        logic [SRC_W-1:0] cand;
        int               idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx  = (int'(ptr) + i) % NREQ;
            cand = SRC_W'(idx);
            if (!found && i_req_valid[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        if (found && allow) grant[gidx] = 1'b1;
    end

    assign xfer        = |grant;
    assign o_req_ready = grant;

    always_comb begin
        sel_data = '0;
        for (int r = 0; r < NREQ; r++)
            if (SRC_W'(r) == gidx) sel_data = i_req_data[r*VW +: VW];
    end

    bound_clamp #(.COLS(COLS), .AB_BW(AB_BW), .BO_BW(BO_BW)) u_clamp (
        .x       (sel_data),
        .lo      (cur_min),
        .hi      (cur_max),
        .y       (clp_data),
        .clamped (clp_any)
    );

    assign push    = stage_vld;
    assign o_valid = (cnt != '0);
    assign pop     = o_valid & i_ready;
    assign o_data  = o_valid ? mem[rd_ptr][OW-1:0]  : '0;
    assign o_src   = o_valid ? mem[rd_ptr][EW-1:OW] : '0;

    assign cfg_ok  = $signed(i_cfg_min) <= $signed(i_cfg_max);
    // Range swap only when nothing clamped under the old range is still in flight.
    assign apply   = pend && (occ == '0) && !xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= SRC_W'(NREQ - 1);
            stage_vld  <= 1'b0;
            stage_data <= '0;
            stage_src  <= '0;
            mem        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            cur_min    <= BO_BW'(RST_MIN);
            cur_max    <= BO_BW'(RST_MAX);
            pend       <= 1'b0;
            pend_min   <= '0;
            pend_max   <= '0;
            sat_cnt    <= '0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err   <= 1'b0;
            stage_vld <= xfer;
            if (xfer) begin
                ptr        <= gidx;
                stage_data <= clp_data;
                stage_src  <= gidx;
                if (clp_any && sat_cnt != '1) sat_cnt <= sat_cnt + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= {stage_src, stage_data};
                wr_ptr      <= fifo_inc(wr_ptr);
            end
            if (pop) rd_ptr <= fifo_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
            // A new write supersedes any pending one; an illegal write is dropped.
            if (i_cfg_we) begin
                if (cfg_ok) begin
                    pend     <= 1'b1;
                    pend_min <= i_cfg_min;
                    pend_max <= i_cfg_max;
                end else begin
                    cfg_err  <= 1'b1;
                end
            end else if (apply) begin
                cur_min <= pend_min;
                cur_max <= pend_max;
                pend    <= 1'b0;
                sat_cnt <= '0;
            end
        end
    end

    assign o_busy    = (occ != '0) || pend;
    assign o_cfg_err = cfg_err;
    assign o_sat_cnt = sat_cnt;
endmodule

// File: tb/tb_bound_arb.sv
// Directed bench for bound_arb: reset state, basic clamp, round-robin,
// backpressure, deferred config, rejected config, reset with a full FIFO.
module tb_bound_arb;
    localparam int NREQ  = 2;
    localparam int COLS  = 5;
    localparam int AB_BW = 25;
    localparam int BO_BW = 8;
    localparam int VW    = COLS * AB_BW;
    localparam int OW    = COLS * BO_BW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*VW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 cfg_we = 1'b0;
    logic [BO_BW-1:0]     cfg_min = '0, cfg_max = '0;
    logic                 cfg_err;
    logic                 o_valid;
    logic [OW-1:0]        o_data;
    logic [0:0]           o_src;
    logic                 i_ready = 1'b1;
    logic                 o_busy;
    logic [15:0]          o_sat_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bound_arb #(.NREQ(NREQ), .COLS(COLS), .AB_BW(AB_BW), .BO_BW(BO_BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .i_cfg_we    (cfg_we),
        .i_cfg_min   (cfg_min),
        .i_cfg_max   (cfg_max),
        .o_cfg_err   (cfg_err),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_src       (o_src),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_sat_cnt   (o_sat_cnt)
    );

    function automatic logic [VW-1:0] pin(input int a, input int b, input int c, input int d, input int e);
        return {AB_BW'(e), AB_BW'(d), AB_BW'(c), AB_BW'(b), AB_BW'(a)};
    endfunction

    function automatic logic [OW-1:0] pout(input int a, input int b, input int c, input int d, input int e);
        return {BO_BW'(e), BO_BW'(d), BO_BW'(c), BO_BW'(b), BO_BW'(a)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        cfg_we    = 1'b0;
        i_ready   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
        n_chk++; if (o_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", o_data); end
        n_chk++; if (o_src !== 1'b0) begin n_fail++; $display("FAIL rst_src: got %b want 0", o_src); end
        n_chk++; if (o_sat_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_sat: got %0d want 0", o_sat_cnt); end
        n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        rst = 1'b0;
        #1;
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b want 01", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_basic();
        do_reset();
        req_valid = 2'b01;
        req_data[0 +: VW] = pin(100, -100, 5, -32, 31);
        #1;
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL basic_ready: got %b want 01", req_ready); end
        @(negedge clk);
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", o_valid); end
        n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", o_busy); end
        req_valid = '0;
        @(negedge clk);
        n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", o_valid); end
        n_chk++; if (o_data !== pout(31, -32, 5, -32, 31)) begin n_fail++; $display("FAIL basic_data: got %h want %h", o_data, pout(31, -32, 5, -32, 31)); end
        n_chk++; if (o_src !== 1'b0) begin n_fail++; $display("FAIL basic_src: got %b want 0", o_src); end
        n_chk++; if (o_sat_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_sat: got %0d want 1", o_sat_cnt); end
        @(negedge clk);
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b want 0", o_valid); end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_rr();
        logic [OW-1:0] e0, e1, exp_d;
        logic [NREQ-1:0] exp_g;
        do_reset();
        e0 = pout(1, 2, 3, 4, 5);
        e1 = pout(-1, -2, -3, -4, -5);
        req_data[0 +: VW]  = pin(1, 2, 3, 4, 5);
        req_data[VW +: VW] = pin(-1, -2, -3, -4, -5);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2 && i <= 13) begin
                exp_d = ((i - 2) % 2 == 0) ? e0 : e1;
                n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want 1", i, o_valid); end
                n_chk++; if (o_src !== 1'((i - 2) % 2)) begin n_fail++; $display("FAIL rr_src[%0d]: got %b want %0d", i, o_src, (i - 2) % 2); end
                n_chk++; if (o_data !== exp_d) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, o_data, exp_d); end
            end else if (i == 14) begin
                n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rr_end_valid: got %b want 0", o_valid); end
            end
            req_valid = (i < 12) ? 2'b11 : 2'b00;
            #1;
            if (i < 12) begin
                exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
                n_chk++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, exp_g); end
            end
        end
        n_chk++; if (o_sat_cnt !== 16'd0) begin n_fail++; $display("FAIL rr_sat: got %0d want 0", o_sat_cnt); end
    endtask

    task automatic test_backpressure();
        int n_acc;
        do_reset();
        i_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2) begin
                n_chk++; if (o_valid !== 1'b1 || o_data !== pout(10, 10, 10, 10, 10)) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, o_valid, o_data, pout(10, 10, 10, 10, 10)); end
            end
            req_valid = 2'b01;
            req_data[0 +: VW] = pin(10 + n_acc, 10 + n_acc, 10 + n_acc, 10 + n_acc, 10 + n_acc);
            #1;
            n_chk++; if (req_ready[0] !== (i < 3)) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", i, req_ready[0], (i < 3)); end
            if (req_ready[0]) n_acc++;
        end
        n_chk++; if (n_acc !== 3) begin n_fail++; $display("FAIL bp_accepted: got %0d want 3", n_acc); end
        @(negedge clk);
        req_valid = '0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (o_valid !== 1'b1 || o_data !== pout(10 + k, 10 + k, 10 + k, 10 + k, 10 + k)) begin n_fail++; $display("FAIL bp_drain[%0d]: got %b/%h want 1/%h", k, o_valid, o_data, pout(10 + k, 10 + k, 10 + k, 10 + k, 10 + k)); end
            @(negedge clk);
        end
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup: got %b want 0", o_valid); end
    endtask

    task automatic test_cfg();
        do_reset();
        req_valid = 2'b01;
        req_data[0 +: VW] = pin(40, 20, -40, 0, 1);
        @(negedge clk);
        req_data[0 +: VW] = pin(-50, 31, 32, -33, 2);
        @(negedge clk);
        n_chk++; if (o_data !== pout(31, 20, -32, 0, 1)) begin n_fail++; $display("FAIL cfg_old_a: got %h want %h", o_data, pout(31, 20, -32, 0, 1)); end
        req_valid = '0;
        cfg_we = 1'b1; cfg_min = -8'sd8; cfg_max = 8'sd7;
        @(negedge clk);
        cfg_we = 1'b0;
        n_chk++; if (o_valid !== 1'b1 || o_data !== pout(-32, 31, 31, -32, 2)) begin n_fail++; $display("FAIL cfg_old_b: got %b/%h want 1/%h", o_valid, o_data, pout(-32, 31, 31, -32, 2)); end
        n_chk++; if (o_sat_cnt !== 16'd2) begin n_fail++; $display("FAIL cfg_sat_before: got %0d want 2", o_sat_cnt); end
        n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL cfg_busy: got %b want 1", o_busy); end
        req_valid = 2'b01;
        req_data[0 +: VW] = pin(20, 20, 20, 20, 20);
        #1;
        n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL cfg_pend_block: got %b want 00", req_ready); end
        @(negedge clk);
        n_chk++; if (req_ready !== 2'b00 || o_sat_cnt !== 16'd2) begin n_fail++; $display("FAIL cfg_not_yet: got %b/%0d want 00/2", req_ready, o_sat_cnt); end
        @(negedge clk);
        n_chk++; if (o_sat_cnt !== 16'd0) begin n_fail++; $display("FAIL cfg_sat_clear: got %0d want 0", o_sat_cnt); end
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL cfg_resume: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_chk++; if (o_sat_cnt !== 16'd1) begin n_fail++; $display("FAIL cfg_sat_new: got %0d want 1", o_sat_cnt); end
        @(negedge clk);
        n_chk++; if (o_valid !== 1'b1 || o_data !== pout(7, 7, 7, 7, 7)) begin n_fail++; $display("FAIL cfg_new_range: got %b/%h want 1/%h", o_valid, o_data, pout(7, 7, 7, 7, 7)); end
    endtask

    task automatic test_cfg_err();
        do_reset();
        cfg_we = 1'b1; cfg_min = 8'sd5; cfg_max = -8'sd5;
        @(negedge clk);
        cfg_we = 1'b0;
        n_chk++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b want 1", cfg_err); end
        @(negedge clk);
        n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_single: got %b want 0", cfg_err); end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL err_no_pend: got %b want 0", o_busy); end
        req_valid = 2'b01;
        req_data[0 +: VW] = pin(40, 40, 40, 40, 40);
        #1;
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL err_ready: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_chk++; if (o_valid !== 1'b1 || o_data !== pout(31, 31, 31, 31, 31)) begin n_fail++; $display("FAIL err_old_range: got %b/%h want 1/%h", o_valid, o_data, pout(31, 31, 31, 31, 31)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_ready = 1'b0;
        req_valid = 2'b01;
        req_data[0 +: VW] = pin(9, 9, 9, 9, 9);
        repeat (5) @(negedge clk);
        req_valid = '0;
        n_chk++; if (o_valid !== 1'b1 || o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_full: got %b/%b want 1/1", o_valid, o_busy); end
        cfg_we = 1'b1; cfg_min = -8'sd8; cfg_max = 8'sd7;
        @(negedge clk);
        cfg_we = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++; if (o_valid !== 1'b0 || o_data !== '0) begin n_fail++; $display("FAIL mid_flush: got %b/%h want 0/0", o_valid, o_data); end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", o_busy); end
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b want 0", i, o_valid); end
        end
        req_valid = 2'b01;
        req_data[0 +: VW] = pin(20, 20, 20, 20, 20);
        #1;
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_ready: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_chk++; if (o_valid !== 1'b1 || o_data !== pout(20, 20, 20, 20, 20)) begin n_fail++; $display("FAIL mid_range: got %b/%h want 1/%h", o_valid, o_data, pout(20, 20, 20, 20, 20)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rr();
        test_backpressure();
        test_cfg();
        test_cfg_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
